// File: rtl/button_conditioner.sv
// Conditions raw board push-buttons into debounced levels and single-cycle,
// one-hot move pulses, issuing at most one move per physical press.
module button_conditioner #(
    parameter int unsigned N_BTN          = 4,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned DB_CYCLES      = 1000000,
    parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst_game,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] buttons,
    output logic [N_BTN-1:0] btn_level,
    output logic             busy
);

    localparam int unsigned CW = $clog2(DB_CYCLES) + 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [N_BTN-1:0]                  pressed;
    logic [SYNC_STAGES-1:0][N_BTN-1:0] sync_q, sync_d;
    logic [N_BTN-1:0]                  sync_out;
    logic [N_BTN-1:0][CW-1:0]          cnt_q, cnt_d;
    logic [N_BTN-1:0]                  level_q, level_d;
    logic [N_BTN-1:0]                  level_dly_q, level_dly_d;
    logic [N_BTN-1:0]                  rise;
    logic [N_BTN-1:0]                  buttons_q, buttons_d;
    logic [0:0]                        state_q, state_d;

    // Polarity is normalised before synchronisation; downstream 1 = pressed.
    assign pressed  = BTN_ACTIVE_LOW ? ~btn_raw : btn_raw;
    assign sync_out = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pressed};
    end

    // A level change is accepted only after DB_CYCLES consecutive differing cycles.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        for (int i = 0; i < int'(N_BTN); i++) begin
            if (sync_out[i] != level_q[i]) begin
                if (cnt_q[i] == CW'(DB_CYCLES - 1)) begin
                    level_d[i] = ~level_q[i];
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    assign level_dly_d = level_q;
    assign rise        = level_q & ~level_dly_q;

    // Arbiter: lowest-index rise wins, then lock out until every button is released.
    always_comb begin
        state_d   = state_q;
        buttons_d = '0;
        case (state_q)
            IDLE: begin
                if (|rise) begin
                    buttons_d = rise & (~rise + N_BTN'(1));
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (level_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_game) begin
        if (!rst_game) begin
            sync_q      <= '0;
            cnt_q       <= '0;
            level_q     <= '0;
            level_dly_q <= '0;
            buttons_q   <= '0;
            state_q     <= IDLE;
        end else begin
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            buttons_q   <= buttons_d;
            state_q     <= state_d;
        end
    end

    assign buttons   = buttons_q;
    assign btn_level = level_q;
    assign busy      = (state_q == HOLD);

endmodule
